neuron_seq_ctrl: RTL
====================

// Module: neuron_seq_ctrl
// PURPOSE
//  Initiator side of the neuron block interface. Accepts one input sample per job by valid/ready,
//  drives the neuron's x/x2..x4/w1..w4/mux pins layer by layer, and fetches weights from a sync-read ROM.
//  Captures the final layer output and returns it to downstream by valid/ready.
//  Sits between the sample stream and one neuron block instance. One job in flight.
// PARAMETERS
//  DW      32  datapath width (neuron x/w width)
//  LW      4   layer-count width; max job = 2**LW-1 layers
//  AW      4   weight ROM address width (>= LW)
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-low
//  flush     in   1      sync abort: return to IDLE next edge, drop job
//  in_valid  in   1      upstream sample valid
//  in_ready  out  1      high only in IDLE
//  in_x      in   DW     first-layer input sample
//  in_layers in   LW     layers to run; 0 treated as 1
//  wt_en     out  1      ROM read strobe
//  wt_addr   out  AW     ROM address = layer index
//  wt_rdata  in   7*DW   {x4,x3,x2,w4,w3,w2,w1}, LSB slice = w1; valid 1 cycle after wt_en
//  n_x       out  DW     to neuron x (neuron registers it internally)
//  n_x2..n_x4 out DW     to neuron side inputs, = wt_rdata slices
//  n_w1..n_w4 out DW     to neuron weights, = wt_rdata slices
//  n_mux     out  1      0: neuron uses its registered x; 1: feedback of its own output
//  n_xo      in   DW     neuron xo (equals neuron output register when n_mux=1)
//  n_o       in   1      neuron nonzero flag
//  out_valid out  1      result valid
//  out_ready in   1      downstream accept
//  out_data  out  DW     final layer result (registered)
//  out_nz    out  1      n_o captured with out_data
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; in_ready=1; wt_en, wt_addr, n_x, n_mux, out_valid, out_data,
//   out_nz all 0. Neuron shares rst; no partial job survives.
//  Neuron timing: n_x latched by neuron at end of cycle c; its output reg holds PU(x,w) at end of c+1.
//  FSM (registered outputs; n_x*/n_w* are combinational pass-through of wt_rdata):
//   IDLE    : in_ready=1. On in_valid: n_x<=in_x, L<=max(in_layers,1), k<=0 -> LOAD.
//   LOAD    : wt_en=1, wt_addr=0, n_mux=0. Neuron latches x. -> RUN.
//   RUN     : 1 cycle per layer k=0..L-1. n_mux=(k!=0). wt_rdata = weights[k].
//             wt_en=(k<L-1), wt_addr=k+1. Neuron out reg <= layer k at end of cycle.
//             k==L-1 -> CAPTURE, else k++.
//   CAPTURE : n_mux=1; out_data<=n_xo, out_nz<=n_o, out_valid<=1 -> OUT.
//   OUT     : hold out_data/out_nz/out_valid; neuron free-runs, its value is ignored.
//             out_valid&out_ready -> out_valid<=0, IDLE.
//  Latency: accepting edge E0 -> out_valid high after edge E0+L+2 (LOAD + L RUN + CAPTURE).
//  Throughput: next accept no earlier than the cycle after the out handshake.
//  in_ready=0 outside IDLE; in_valid there ignored (no queueing).
//  flush: wins over every transition incl. out handshake; IDLE next edge; out_valid<=0; wt_en<=0.
//  out_ready held low: out_data stable indefinitely, no ROM reads issued.
//  in_layers=2**LW-1: wt_addr wraps only by width; AW>=LW prevents aliasing.
//  Arithmetic done entirely in the neuron (incl. ReLU); this block only moves words, no width change.
// STRUCTURE
//  Shared package nn_pkg: DW default, state encoding (IDLE,LOAD,RUN,CAPTURE,OUT),
//   wt_rdata slice offsets W1_LSB..X4_LSB.
//  One sub-module: nn_layer_cnt (load L, count k, assert last when k==L-1).
// TESTING
//  Bench uses an integer neuron model: out = relu(x*w1+x2*w2+x3*w3+x4*w4), low DW bits, 2's complement.
//  T1: in_x=3, L=3, all layers w1=2 else 0 -> out_data=24, out_nz=1, out_valid after E0+5.
//  T2: in_x=5, L=1, w1=-1 -> out_data=0, out_nz=0 (ReLU clamp).
//  T3: in_layers=0, in_x=7, w1=1 -> behaves as L=1: out_data=7; exactly one wt_en pulse, addr 0.
//  T4: out_ready low 20 cycles after result -> out_data/out_valid stable; in_ready=0; wt_en=0 throughout.
//  T5: rst low during RUN k=1 of L=4 -> all outputs 0 immediately; next job x=1,w1=3,L=2 -> 9.
//  T6: flush asserted in CAPTURE -> no out_valid; IDLE next cycle; following job correct.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron sequencing controller: default width,
// FSM state encoding and the slot layout of the weight ROM word.
package nn_pkg;

  localparam int unsigned NN_DW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_OUT
  } state_t;

  // ROM word = {x4,x3,x2,w4,w3,w2,w1}; offsets below are for the default width
  localparam int unsigned W1_LSB = 0 * NN_DW;
  localparam int unsigned W2_LSB = 1 * NN_DW;
  localparam int unsigned W3_LSB = 2 * NN_DW;
  localparam int unsigned W4_LSB = 3 * NN_DW;
  localparam int unsigned X2_LSB = 4 * NN_DW;
  localparam int unsigned X3_LSB = 5 * NN_DW;
  localparam int unsigned X4_LSB = 6 * NN_DW;

  // Rescale a default-width slot offset to an instance with a different width
  function automatic int unsigned slot_lsb(input int unsigned def_lsb, input int unsigned dw);
    return (def_lsb / NN_DW) * dw;
  endfunction

endpackage

// File: rtl/nn_layer_cnt.sv
// Layer counter: loads the layer count (0 treated as 1), steps k, and flags
// the last layer and the one before it.
module nn_layer_cnt #(
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] layers,
  input  logic          inc,
  output logic [LW-1:0] k,
  output logic          last,
  output logic          penult
);

  // Holds L-1 so that a zero layer count collapses onto a single layer
  logic [LW-1:0] lmax;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k    <= '0;
      lmax <= '0;
    end else if (load) begin
      k    <= '0;
      lmax <= (layers == '0) ? '0 : layers - LW'(1);
    end else if (inc) begin
      k <= k + LW'(1);
    end
  end

  always_comb begin
    last   = (k == lmax);
    penult = ((k + LW'(1)) == lmax);
  end

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Initiator side of the neuron block: takes one sample, steps the neuron through
// its layers with ROM-fetched weights, and returns the final layer result.
module neuron_seq_ctrl
  import nn_pkg::*;
#(
  parameter int unsigned DW = NN_DW,
  parameter int unsigned LW = 4,
  parameter int unsigned AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_x,
  input  logic [LW-1:0]   in_layers,
  output logic            wt_en,
  output logic [AW-1:0]   wt_addr,
  input  logic [7*DW-1:0] wt_rdata,
  output logic [DW-1:0]   n_x,
  output logic [DW-1:0]   n_x2,
  output logic [DW-1:0]   n_x3,
  output logic [DW-1:0]   n_x4,
  output logic [DW-1:0]   n_w1,
  output logic [DW-1:0]   n_w2,
  output logic [DW-1:0]   n_w3,
  output logic [DW-1:0]   n_w4,
  output logic            n_mux,
  input  logic [DW-1:0]   n_xo,
  input  logic            n_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_nz
);

  localparam int unsigned W1_OFS = slot_lsb(W1_LSB, DW);
  localparam int unsigned W2_OFS = slot_lsb(W2_LSB, DW);
  localparam int unsigned W3_OFS = slot_lsb(W3_LSB, DW);
  localparam int unsigned W4_OFS = slot_lsb(W4_LSB, DW);
  localparam int unsigned X2_OFS = slot_lsb(X2_LSB, DW);
  localparam int unsigned X3_OFS = slot_lsb(X3_LSB, DW);
  localparam int unsigned X4_OFS = slot_lsb(X4_LSB, DW);

  state_t          state, state_d;
  logic            wt_en_d, n_mux_d, out_valid_d, out_nz_d;
  logic [AW-1:0]   wt_addr_d;
  logic [DW-1:0]   n_x_d, out_data_d;
  logic            cnt_load, cnt_inc;
  logic [LW-1:0]   k;
  logic            last, penult;

  nn_layer_cnt #(.LW(LW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .layers (in_layers),
    .inc    (cnt_inc),
    .k      (k),
    .last   (last),
    .penult (penult)
  );

  assign n_w1 = wt_rdata[W1_OFS +: DW];
  assign n_w2 = wt_rdata[W2_OFS +: DW];
  assign n_w3 = wt_rdata[W3_OFS +: DW];
  assign n_w4 = wt_rdata[W4_OFS +: DW];
  assign n_x2 = wt_rdata[X2_OFS +: DW];
  assign n_x3 = wt_rdata[X3_OFS +: DW];
  assign n_x4 = wt_rdata[X4_OFS +: DW];

  assign in_ready = (state == S_IDLE);

  // Next values of all registered outputs are formed here so each output
  // carries the value belonging to the state being entered.
  always_comb begin
    state_d     = state;
    wt_en_d     = wt_en;
    wt_addr_d   = wt_addr;
    n_x_d       = n_x;
    n_mux_d     = n_mux;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_nz_d    = out_nz;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          n_x_d     = in_x;
          cnt_load  = 1'b1;
          wt_en_d   = 1'b1;
          wt_addr_d = '0;
          n_mux_d   = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        n_mux_d   = 1'b0;
        wt_en_d   = !last;
        wt_addr_d = AW'(k) + AW'(1);
        state_d   = S_RUN;
      end
      S_RUN: begin
        n_mux_d = 1'b1;
        if (last) begin
          wt_en_d = 1'b0;
          state_d = S_CAPTURE;
        end else begin
          cnt_inc   = 1'b1;
          wt_en_d   = !penult;
          wt_addr_d = AW'(k) + AW'(2);
        end
      end
      S_CAPTURE: begin
        out_data_d  = n_xo;
        out_nz_d    = n_o;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          n_mux_d     = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      wt_en_d     = 1'b0;
      n_mux_d     = 1'b0;
      out_valid_d = 1'b0;
      n_x_d       = n_x;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wt_en     <= 1'b0;
      wt_addr   <= '0;
      n_x       <= '0;
      n_mux     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nz    <= 1'b0;
    end else begin
      state     <= state_d;
      wt_en     <= wt_en_d;
      wt_addr   <= wt_addr_d;
      n_x       <= n_x_d;
      n_mux     <= n_mux_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_nz    <= out_nz_d;
    end
  end

endmodule
